// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_unit_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  localparam addr_t RESET_PC = 32'hbfc0_0000;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  valid;
    word_t data;
  } ibus_resp_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction bus, decode handoff and redirect signals of the fetch unit
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  ireq_valid;
  addr_t ireq_addr;
  logic  ireq_ready;
  logic  iresp_valid;
  word_t iresp_data;

  logic  out_valid;
  addr_t out_pc;
  word_t out_instr;
  logic  out_fault;
  logic  out_ready;

  logic  redirect_valid;
  addr_t redirect_pc;

  modport master (
    output ireq_valid, ireq_addr,
    input  ireq_ready, iresp_valid, iresp_data,
    output out_valid, out_pc, out_instr, out_fault,
    input  out_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output ireq_ready, iresp_valid, iresp_data,
    input  out_valid, out_pc, out_instr, out_fault,
    output out_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_unit_pc_gen.sv
// rtl/fetch_unit_pc_gen.sv - next-PC select and alignment check; FETCH_ADDR_CHECK_EN enables fault on misaligned PC
module fetch_pc_gen
  import fetch_unit_pkg::*;
(
  input  addr_t pc,
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  input  logic  advance,
  output addr_t pc_next,
  output addr_t bus_addr,
  output logic  misaligned
);

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (advance) begin
      pc_next = pc + 32'd4;
    end
  end

`ifdef FETCH_ADDR_CHECK_EN
  assign misaligned = |pc[1:0];
  assign bus_addr   = pc;
`else
  // Without the check the low bits are simply dropped on the bus.
  assign misaligned = 1'b0;
  assign bus_addr   = {pc[31:2], 2'b00};
`endif

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch FSM and holding registers; FETCH_ADDR_CHECK_EN (in fetch_pc_gen) adds misaligned-PC faults
module fetch_unit #(
  parameter fetch_unit_pkg::addr_t RESET_PC = fetch_unit_pkg::RESET_PC
) (
  input logic          clk,
  input logic          resetn,
  fetch_unit_if.master bus
);
  import fetch_unit_pkg::*;

  fetch_state_t state, state_d;
  addr_t        pc, pc_next, bus_addr;
  word_t        instr_q;
  logic         fault_q;
  logic         misaligned;
  logic         advance, capture_data, capture_fault;
  ibus_req_t    ireq;
  ibus_resp_t   iresp;

  fetch_pc_gen u_pc_gen (
    .pc             (pc),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .advance        (advance),
    .pc_next        (pc_next),
    .bus_addr       (bus_addr),
    .misaligned     (misaligned)
  );

  assign iresp = '{valid: bus.iresp_valid, data: bus.iresp_data};
  assign ireq  = '{valid: (state == S_REQ) && !misaligned, addr: bus_addr};

  assign bus.ireq_valid = ireq.valid;
  assign bus.ireq_addr  = ireq.addr;
  assign bus.out_valid  = (state == S_HOLD);
  assign bus.out_pc     = pc;
  assign bus.out_instr  = instr_q;
  assign bus.out_fault  = fault_q;

  // Redirect wins everywhere; pc_gen applies it to pc independently of state.
  always_comb begin
    state_d       = state;
    advance       = 1'b0;
    capture_data  = 1'b0;
    capture_fault = 1'b0;
    case (state)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (misaligned) begin
          if (!bus.redirect_valid) begin
            state_d       = S_HOLD;
            capture_fault = 1'b1;
          end
        end else if (bus.ireq_ready) begin
          state_d = bus.redirect_valid ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          state_d = iresp.valid ? S_REQ : S_DRAIN;
        end else if (iresp.valid) begin
          state_d      = S_HOLD;
          capture_data = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          state_d = S_REQ;
        end else if (bus.out_ready) begin
          state_d = S_REQ;
          advance = 1'b1;
        end
      end
      S_DRAIN: begin
        if (iresp.valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_next;
      if (capture_data) begin
        instr_q <= iresp.data;
        fault_q <= 1'b0;
      end else if (capture_fault) begin
        instr_q <= '0;
        fault_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    addr_t pc;
    word_t instr;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fetch_unit_if bif();

  fetch_unit #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif.master)
  );

  int    errors = 0;
  int    checks = 0;
  int    n_cons = 0;
  int    cyc = 0;
  exp_t  sb_q[$];
  addr_t acc_addr[$];
  int    acc_cyc[$];
  addr_t exp_pc;
  bit    stale_seen = 0;
  bit    auto_resp = 1;
  word_t resp_word;

  always @(negedge clk) begin
    if (resetn) begin
      if (bif.out_valid && bif.out_instr === 32'hdead_beef) stale_seen = 1;
      if (bif.redirect_valid) begin
        sb_q.delete();
        exp_pc = bif.redirect_pc;
      end else begin
        if (bif.ireq_valid && bif.ireq_ready) begin
          sb_q.push_back('{exp_pc, resp_word});
          acc_addr.push_back(bif.ireq_addr);
          acc_cyc.push_back(cyc);
        end
        if (bif.out_valid && bif.out_ready) begin
          exp_t e;
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: out_pc=%h consumed but nothing expected", bif.out_pc);
          end else begin
            e = sb_q.pop_front();
            if (bif.out_pc !== e.pc || bif.out_instr !== e.instr || bif.out_fault !== 1'b0) begin
              errors++;
              $display("FAIL sb_item: got pc=%h instr=%h fault=%b want pc=%h instr=%h fault=0",
                       bif.out_pc, bif.out_instr, bif.out_fault, e.pc, e.instr);
            end
          end
          n_cons++;
          exp_pc += 32'd4;
        end
      end
    end
  end

  task automatic cycle();
    logic  acc;
    word_t w;
    acc = bif.ireq_valid && bif.ireq_ready && auto_resp;
    w   = resp_word;
    @(posedge clk);
    #1;
    bif.iresp_valid = acc;
    bif.iresp_data  = acc ? w : 32'h0;
    cyc++;
  endtask

  task automatic wait_ireq(input string name);
    for (int i = 0; i < 20 && bif.ireq_valid !== 1'b1; i++) cycle();
    if (bif.ireq_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_wait_ireq: ireq_valid=%b want 1 within 20 cycles", name, bif.ireq_valid);
    end
  endtask

  task automatic wait_out(input string name);
    for (int i = 0; i < 20 && bif.out_valid !== 1'b1; i++) cycle();
    if (bif.out_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_wait_out: out_valid=%b want 1 within 20 cycles", name, bif.out_valid);
    end
  endtask

  task automatic wait_cons(input string name);
    int start;
    start = n_cons;
    for (int i = 0; i < 20 && n_cons == start; i++) cycle();
    if (n_cons == start) begin
      checks++; errors++;
      $display("FAIL %s_wait_cons: no instruction consumed within 20 cycles", name);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    acc_addr.delete();
    acc_cyc.delete();
    exp_pc = 32'hbfc0_0000;
    bif.iresp_valid = 1'b0;
    bif.iresp_data  = 32'h0;
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (bif.ireq_valid !== 1'b0 || bif.ireq_addr !== 32'hbfc0_0000) begin
      errors++;
      $display("FAIL %s_ireq: valid=%b addr=%h want 0 bfc00000", name, bif.ireq_valid, bif.ireq_addr);
    end
    checks++;
    if (bif.out_valid !== 1'b0 || bif.out_pc !== 32'hbfc0_0000) begin
      errors++;
      $display("FAIL %s_out: valid=%b pc=%h want 0 bfc00000", name, bif.out_valid, bif.out_pc);
    end
    checks++;
    if (bif.out_instr !== 32'h0 || bif.out_fault !== 1'b0) begin
      errors++;
      $display("FAIL %s_data: instr=%h fault=%b want 0 0", name, bif.out_instr, bif.out_fault);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_reset();
    repeat (3) cycle();
    check_reset_vals("reset");
    bif.ireq_ready = 1'b1;
    bif.out_ready  = 1'b1;
    resp_word      = 32'h2408_0001;
    resetn         = 1'b1;
    cycle();
    checks++;
    if (bif.ireq_valid !== 1'b1 || bif.ireq_addr !== 32'hbfc0_0000) begin
      errors++;
      $display("FAIL first_req: valid=%b addr=%h want 1 bfc00000", bif.ireq_valid, bif.ireq_addr);
    end
  endtask

  task automatic test_stream();
    addr_t want[3];
    want[0] = 32'hbfc0_0000;
    want[1] = 32'hbfc0_0004;
    want[2] = 32'hbfc0_0008;
    acc_addr.delete();
    acc_cyc.delete();
    repeat (9) cycle();
    checks++;
    if (acc_addr.size() < 3) begin
      errors++;
      $display("FAIL stream_count: %0d requests accepted, want at least 3", acc_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_addr[i] !== want[i]) begin
          errors++;
          $display("FAIL stream_addr%0d: got %h want %h", i, acc_addr[i], want[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
          errors++;
          $display("FAIL stream_period%0d: got %0d cycles want 3", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    bif.out_ready = 1'b0;
    resp_word     = 32'h1234_5678;
    wait_out("stall");
    e = sb_q.size() > 0 ? sb_q[0] : '{32'hffff_ffff, 32'hffff_ffff};
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (bif.out_valid !== 1'b1 || bif.ireq_valid !== 1'b0 ||
          bif.out_pc !== e.pc || bif.out_instr !== e.instr) begin
        errors++;
        $display("FAIL stall_hold%0d: got ov=%b iv=%b pc=%h instr=%h want 1 0 %h %h",
                 i, bif.out_valid, bif.ireq_valid, bif.out_pc, bif.out_instr, e.pc, e.instr);
      end
    end
    bif.out_ready = 1'b1;
    cycle();
    checks++;
    if (bif.ireq_valid !== 1'b1 || bif.ireq_addr !== e.pc + 32'd4) begin
      errors++;
      $display("FAIL stall_release: valid=%b addr=%h want 1 %h", bif.ireq_valid, bif.ireq_addr, e.pc + 32'd4);
    end
  endtask

  task automatic test_redirect_drain();
    bif.ireq_ready = 1'b0;
    bif.out_ready  = 1'b1;
    wait_ireq("drain");
    stale_seen         = 0;
    bif.ireq_ready     = 1'b1;
    bif.redirect_valid = 1'b1;
    bif.redirect_pc    = 32'h8000_0100;
    resp_word          = 32'hdead_beef;
    cycle();
    bif.redirect_valid = 1'b0;
    resp_word          = 32'h3c1d_0000;
    checks++;
    if (bif.ireq_valid !== 1'b0 || bif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: iv=%b ov=%b want 0 0", bif.ireq_valid, bif.out_valid);
    end
    cycle();
    checks++;
    if (bif.ireq_valid !== 1'b1 || bif.ireq_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL drain_next: valid=%b addr=%h want 1 80000100", bif.ireq_valid, bif.ireq_addr);
    end
    wait_cons("drain");
    checks++;
    if (stale_seen) begin
      errors++;
      $display("FAIL drain_stale: out_instr showed dead_beef, want never");
    end
  endtask

  task automatic test_redirect_hold();
    bif.out_ready = 1'b0;
    resp_word     = 32'h0000_0021;
    wait_out("hold");
    bif.redirect_valid = 1'b1;
    bif.redirect_pc    = 32'h8000_0200;
    bif.out_ready      = 1'b1;
    cycle();
    bif.redirect_valid = 1'b0;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.ireq_valid !== 1'b1 || bif.ireq_addr !== 32'h8000_0200) begin
      errors++;
      $display("FAIL hold_redirect: ov=%b iv=%b addr=%h want 0 1 80000200",
               bif.out_valid, bif.ireq_valid, bif.ireq_addr);
    end
    wait_cons("hold");
  endtask

  task automatic test_misaligned();
    bif.ireq_ready = 1'b0;
    bif.out_ready  = 1'b1;
    resp_word      = 32'h8c02_0004;
    wait_ireq("misal");
    bif.redirect_valid = 1'b1;
    bif.redirect_pc    = 32'h8000_0102;
    cycle();
    bif.redirect_valid = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
    bif.out_ready = 1'b0;
    checks++;
    if (bif.ireq_valid !== 1'b0) begin
      errors++;
      $display("FAIL misal_noreq: ireq_valid=%b want 0", bif.ireq_valid);
    end
    cycle();
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_fault !== 1'b1 ||
        bif.out_instr !== 32'h0 || bif.out_pc !== 32'h8000_0102) begin
      errors++;
      $display("FAIL misal_fault: ov=%b fault=%b instr=%h pc=%h want 1 1 0 80000102",
               bif.out_valid, bif.out_fault, bif.out_instr, bif.out_pc);
    end
    bif.redirect_valid = 1'b1;
    bif.redirect_pc    = 32'h8000_0200;
    cycle();
    bif.redirect_valid = 1'b0;
    bif.out_ready      = 1'b1;
`else
    checks++;
    if (bif.ireq_valid !== 1'b1 || bif.ireq_addr !== 32'h8000_0100 || bif.out_pc !== 32'h8000_0102) begin
      errors++;
      $display("FAIL misal_addr: iv=%b addr=%h pc=%h want 1 80000100 80000102",
               bif.ireq_valid, bif.ireq_addr, bif.out_pc);
    end
    bif.ireq_ready = 1'b1;
    wait_cons("misal");
`endif
  endtask

  task automatic test_reset_midflight();
    bif.ireq_ready = 1'b1;
    bif.out_ready  = 1'b1;
    resp_word      = 32'h2409_0002;
    wait_ireq("midrst");
    auto_resp = 0;
    cycle();
    checks++;
    if (bif.ireq_valid !== 1'b0 || bif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_wait: iv=%b ov=%b want 0 0", bif.ireq_valid, bif.out_valid);
    end
    #2;
    resetn = 1'b0;
    #1;
    check_reset_vals("midrst");
    model_reset();
    auto_resp = 1;
    repeat (2) cycle();
    resetn = 1'b1;
    cycle();
    checks++;
    if (bif.ireq_valid !== 1'b1 || bif.ireq_addr !== 32'hbfc0_0000) begin
      errors++;
      $display("FAIL midrst_restart: valid=%b addr=%h want 1 bfc00000", bif.ireq_valid, bif.ireq_addr);
    end
    wait_cons("midrst");
  endtask

  initial begin
    bif.ireq_ready     = 1'b0;
    bif.iresp_valid    = 1'b0;
    bif.iresp_data     = 32'h0;
    bif.out_ready      = 1'b0;
    bif.redirect_valid = 1'b0;
    bif.redirect_pc    = 32'h0;
    resp_word          = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_hold();
    test_misaligned();
    test_reset_midflight();
    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the multi-cycle reference CPU, directly upstream of the decode step. Issues one instruction-bus read per PC and captures the returned word. Presents `{pc, instr, fault}` to decode through a valid/ready handshake. Accepts PC redirects from the branch/commit path and squashes in-flight or held fetches.

## Interface
- `RESET_PC`, default `32'hbfc0_0000`: first PC fetched after reset.
- `clk` in 1: clock, all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ireq_valid` out 1: instruction-bus read request.
- `ireq_addr` out 32: request address.
- `ireq_ready` in 1: bus accepts the request this cycle (addr_ok).
- `iresp_valid` in 1: read data returned this cycle (data_ok).
- `iresp_data` in 32: returned instruction word.
- `out_valid` out 1: fetched instruction available to decode.
- `out_pc` out 32: PC of the presented instruction.
- `out_instr` out 32: instruction word.
- `out_fault` out 1: fetch address error for `out_pc`.
- `out_ready` in 1: decode consumes the presented instruction.
- `redirect_valid` in 1: replace the fetch PC.
- `redirect_pc` in 32: new PC.

## Operation
- States:
  - `S_IDLE`: reset state only.
  - `S_REQ`: `ireq_valid`=1.
  - `S_WAIT`: request accepted, awaiting data.
  - `S_HOLD`: `out_valid`=1.
  - `S_DRAIN`: discard one stale response.
- Outputs are decoded from registered state: `ireq_valid` = (state==`S_REQ`), `out_valid` = (state==`S_HOLD`).
- `ireq_addr` = current `pc` register.
- Transitions, with no redirect:
  - `S_IDLE` → `S_REQ` unconditionally.
  - `S_REQ` → `S_WAIT` when `ireq_ready`.
  - `S_WAIT` → `S_HOLD` when `iresp_valid`; capture `iresp_data` into `out_instr`.
  - `S_HOLD` → `S_REQ` when `out_ready`, with `pc` ← `pc`+4 (mod 2^32, wraps silently).
- Redirect (highest priority, takes effect in every state):
  - `S_REQ` with `ireq_ready`=0: `pc` ← `redirect_pc`, stay in `S_REQ`.
  - `S_REQ` with `ireq_ready`=1: the old address is already accepted. `pc` ← `redirect_pc`, go to `S_DRAIN`.
  - `S_WAIT` with `iresp_valid`=1: drop the data, `pc` ← `redirect_pc`, go to `S_REQ`.
  - `S_WAIT` with `iresp_valid`=0: `pc` ← `redirect_pc`, go to `S_DRAIN`.
  - `S_HOLD`: drop the held instruction even if `out_ready`=1 in the same cycle; `pc` ← `redirect_pc`, go to `S_REQ`.
  - `S_DRAIN`: update `pc` only.
  - `S_IDLE`: `pc` ← `redirect_pc`, go to `S_REQ`.
- `S_DRAIN` → `S_REQ` on `iresp_valid`; the data is discarded.
- `iresp_valid` is ignored in `S_IDLE`, `S_REQ` and `S_HOLD`. The bus guarantees data_ok comes no earlier than the cycle after addr_ok, with at most one read outstanding.
- `out_pc` tracks `pc`. `out_instr` and `out_fault` are stable for the whole time `out_valid`=1.

## Timing
- Reset values: state `S_IDLE`, `pc`=`RESET_PC`, `ireq_valid`=0, `ireq_addr`=`RESET_PC`, `out_valid`=0, `out_pc`=`RESET_PC`, `out_instr`=0, `out_fault`=0.
- First `ireq_valid` appears one cycle after `resetn` deasserts.
- Best-case per-instruction cycle, with immediate addr_ok, data_ok on the next cycle and decode ready: `S_REQ`, `S_WAIT`, `S_HOLD` = 3 cycles.
- `out_valid` rises the cycle after the `iresp_valid` that is captured.
- Redirect to new request:
  - Redirect accepted in cycle N from `S_REQ`/`S_HOLD`/`S_IDLE`: `ireq_addr`=`redirect_pc` at N+1.
  - From `S_DRAIN`: one cycle after the stale response.
- Reset asserted mid-transaction: immediate return to reset values. Any bus response arriving after reset is ignored in `S_IDLE`/`S_REQ`; the bus is reset alongside.

## Configuration
- Macro `FETCH_ADDR_CHECK_EN`.
- Defined: in `S_REQ`, if `pc[1:0]`≠0, no bus request is issued (`ireq_valid`=0). Next state is `S_HOLD` with `out_fault`=1 and `out_instr`=0. Redirect priority still applies.
- Undefined: `ireq_addr` = {`pc[31:2]`, 2'b00}, and `out_fault` is constant 0.

## Structure
- Shared defs header/package holds:
  - `addr_t` and `word_t` (32-bit).
  - `fetch_state_t` enum.
  - `RESET_PC` default constant.
  - `ibus_req_t`/`ibus_resp_t` structs mirroring the port groups.
- One sub-module, `fetch_pc_gen`: next-PC selection (redirect, +4, hold) plus the alignment check.
- FSM and holding registers stay in `fetch_unit`.

## Test plan
- Reset release, `ireq_ready`=1 always, data_ok 1 cycle later with `iresp_data`=`32'h2408_0001`, `out_ready`=1 → `ireq_addr` `bfc0_0000`, `bfc0_0004`, `bfc0_0008`; a new instruction every 3 cycles.
- `out_ready` held 0 for 5 cycles → `out_valid`, `out_pc`, `out_instr` constant, no new `ireq_valid`; release → `pc` advances by 4.
- Redirect to `8000_0100` in the same cycle as `ireq_ready` → `S_DRAIN`. Stale data `dead_beef` never appears on `out_instr`. Next `ireq_addr`=`8000_0100`.
- Redirect in `S_HOLD` with `out_ready`=1 simultaneously → held instruction not counted as consumed. Next request is to `redirect_pc`, not `pc`+4.
- `FETCH_ADDR_CHECK_EN` defined, redirect to `8000_0102` → no bus request, `out_valid`=1, `out_fault`=1, `out_pc`=`8000_0102`. Undefined: `ireq_addr`=`8000_0100`.
- `resetn` pulsed low while in `S_WAIT` → all outputs at reset values asynchronously. Fetch restarts at `RESET_PC`.
